ram_test_master: RTL and testbench

RAM_TEST_MASTER -- requirements
Module: ram_test_master

---
 rtl/ram_test_master_pkg.sv | 18 +
 rtl/ram_test_watchdog.sv | 28 ++
 rtl/ram_test_master.sv | 164 ++++++++++++++++
 tb/tb_ram_test_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_test_master_pkg.sv
// Shared types and constants for the RAM test master and its watchdog.
package ram_test_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        FINISH
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam logic [7:0] DEFAULT_PATTERN_SEED = 8'hA5;

endpackage

// File: rtl/ram_test_watchdog.sv
// Cycle watchdog for the test master: counts wait cycles since the last start
// and flags expiry once TIMEOUT_CYCLES wait cycles have elapsed.
module ram_test_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic count_en,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (reload) begin
            count <= '0;
        end else if (count_en && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    // count holds n-1 during the n-th wait cycle
    assign expired = count_en && (count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ram_test_master.sv
// Write-then-read RAM test master; data = address ^ PATTERN_SEED.
// Define RAM_TEST_TIMEOUT_EN to add a watchdog on the WAIT states.
module ram_test_master
    import ram_test_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] PATTERN_SEED = DATA_WIDTH'(DEFAULT_PATTERN_SEED)
`ifdef RAM_TEST_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  start,
    output logic                  rw,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  done,
    output logic                  busy,
    output logic                  finished,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  timeout
);

    // one spare bit so DEPTH == 2**ADDR_WIDTH still has a distinct last index
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] LAST = AW1'(DEPTH - 1);

    state_t         state;
    logic [AW1-1:0] addr;
    logic [AW1-1:0] addr_inc;
    logic           last;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [AW1-1:0] a);
        return DATA_WIDTH'(a) ^ PATTERN_SEED;
    endfunction

    assign addr_inc = addr + AW1'(1);
    assign last     = (addr == LAST);

`ifdef RAM_TEST_TIMEOUT_EN
    logic expired;
    logic timeout_flag;

    ram_test_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .reload  (start),
        .count_en(state == WR_WAIT || state == RD_WAIT),
        .expired (expired)
    );

    assign timeout = timeout_flag;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            addr       <= '0;
            start      <= 1'b0;
            rw         <= RW_READ;
            address    <= '0;
            write_data <= '0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
`ifdef RAM_TEST_TIMEOUT_EN
            timeout_flag <= 1'b0;
`endif
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: if (run) begin
                    err_count  <= '0;
                    fail_addr  <= '0;
                    fail_data  <= '0;
                    finished   <= 1'b0;
                    pass       <= 1'b0;
                    busy       <= 1'b1;
                    addr       <= '0;
                    start      <= 1'b1;
                    rw         <= RW_WRITE;
                    address    <= '0;
                    write_data <= pattern('0);
                    state      <= WR_ISSUE;
`ifdef RAM_TEST_TIMEOUT_EN
                    timeout_flag <= 1'b0;
`endif
                end
                WR_ISSUE: state <= WR_WAIT;
                WR_WAIT: if (done) begin
                    start <= 1'b1;
                    if (last) begin
                        addr    <= '0;
                        rw      <= RW_READ;
                        address <= '0;
                        state   <= RD_ISSUE;
                    end else begin
                        addr       <= addr_inc;
                        address    <= addr_inc[ADDR_WIDTH-1:0];
                        write_data <= pattern(addr_inc);
                        state      <= WR_ISSUE;
                    end
                end
`ifdef RAM_TEST_TIMEOUT_EN
                else if (expired) begin
                    timeout_flag <= 1'b1;
                    state        <= FINISH;
                end
`endif
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: if (done) begin
                    if (read_data != pattern(addr)) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (err_count == 16'd0) begin
                            fail_addr <= addr[ADDR_WIDTH-1:0];
                            fail_data <= read_data;
                        end
                    end
                    if (last) begin
                        state <= FINISH;
                    end else begin
                        addr    <= addr_inc;
                        start   <= 1'b1;
                        address <= addr_inc[ADDR_WIDTH-1:0];
                        state   <= RD_ISSUE;
                    end
                end
`ifdef RAM_TEST_TIMEOUT_EN
                else if (expired) begin
                    timeout_flag <= 1'b1;
                    state        <= FINISH;
                end
`endif
                FINISH: begin
                    finished <= 1'b1;
                    busy     <= 1'b0;
`ifdef RAM_TEST_TIMEOUT_EN
                    pass     <= (err_count == 16'd0) && !timeout_flag;
`else
                    pass     <= (err_count == 16'd0);
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_test_master.sv
// Directed bench: a full-depth master against a latency-controlled RAM model,
// plus a DEPTH=4 master whose responder also fires done in the start cycle.
module tb_ram_test_master;

    logic       clk = 1'b0;
    logic       rst, run, run4;
    logic       start, rw, done, busy, finished, pass, timeout;
    logic [7:0] address, write_data, read_data, fail_addr, fail_data;
    logic [15:0] err_count;

    logic       start4, rw4, done4, busy4, finished4, pass4, timeout4;
    logic [7:0] address4, write_data4, read_data4, fail_addr4, fail_data4;
    logic [15:0] err_count4;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ram_test_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .run(run), .start(start), .rw(rw), .address(address),
        .write_data(write_data), .read_data(read_data), .done(done), .busy(busy),
        .finished(finished), .pass(pass), .err_count(err_count), .fail_addr(fail_addr),
        .fail_data(fail_data), .timeout(timeout)
    );

    ram_test_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .run(run4), .start(start4), .rw(rw4), .address(address4),
        .write_data(write_data4), .read_data(read_data4), .done(done4), .busy(busy4),
        .finished(finished4), .pass(pass4), .err_count(err_count4), .fail_addr(fail_addr4),
        .fail_data(fail_data4), .timeout(timeout4)
    );

    // RAM model for the full-depth master: done arrives lat cycles after the minimum
    logic [7:0] mem [256];
    int         lat = 0;
    logic [1:0] corrupt = 2'b00;
    logic       nodone = 1'b0;
    logic       pend = 1'b0;
    int         cnt = 0;
    logic [7:0] a_q = '0;
    int         nstart = 0;

    function automatic logic [7:0] rd(input logic [7:0] a);
        if ((corrupt[0] && a == 8'h10) || (corrupt[1] && a == 8'h20)) return 8'h00;
        return mem[a];
    endfunction

    initial begin
        done = 1'b0;
        read_data = '0;
    end

    always @(posedge clk) begin
        done <= 1'b0;
        if (start) begin
            nstart <= nstart + 1;
            if (rw) mem[address] <= write_data;
            a_q <= address;
            if (nodone) begin
                pend <= 1'b0;
            end else if (lat == 0) begin
                pend      <= 1'b0;
                done      <= 1'b1;
                read_data <= rd(address);
            end else begin
                pend <= 1'b1;
                cnt  <= lat - 1;
            end
        end else if (pend) begin
            if (cnt == 0) begin
                pend      <= 1'b0;
                done      <= 1'b1;
                read_data <= rd(a_q);
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // DEPTH=4 responder: a spurious done alongside start, the real one two cycles later
    logic [7:0]  mem4 [4];
    logic [1:0]  a4 = '0;
    logic        d1 = 1'b0, late4 = 1'b0;
    logic [16:0] log4 [$];

    assign done4      = start4 | late4;
    assign read_data4 = mem4[a4];

    always @(posedge clk) begin
        d1    <= start4;
        late4 <= d1;
        if (start4) begin
            if (rw4) mem4[address4[1:0]] <= write_data4;
            a4 <= address4[1:0];
            log4.push_back({rw4, address4, write_data4});
        end
    end

    logic prev_s = 1'b0, prev_s4 = 1'b0, b2b = 1'b0;
    always @(posedge clk) begin
        prev_s  <= start;
        prev_s4 <= start4;
        if ((start && prev_s) || (start4 && prev_s4)) b2b <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_fin(input string tag, input int bound);
        int n = 0;
        while (finished !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " finished within bound"}, finished, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " start"}, start, 0);
        chk({tag, " rw"}, rw, 0);
        chk({tag, " address"}, address, 0);
        chk({tag, " write_data"}, write_data, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " finished"}, finished, 0);
        chk({tag, " pass"}, pass, 0);
        chk({tag, " err_count"}, err_count, 0);
        chk({tag, " fail_addr"}, fail_addr, 0);
        chk({tag, " fail_data"}, fail_data, 0);
        chk({tag, " timeout"}, timeout, 0);
    endtask

    initial begin
        int s0;
        int n;
        logic [7:0] wexp [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

        rst = 1'b0; run = 1'b0; run4 = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset busy4", busy4, 0);
        rst = 1'b1;
        @(negedge clk);

        // clean pass, minimum latency
        s0 = nstart;
        pulse_run();
        chk("first busy", busy, 1);
        chk("first start", start, 1);
        chk("first rw", rw, 1);
        chk("first address", address, 8'h00);
        chk("first write_data", write_data, 8'hA5);
        @(negedge clk);
        chk("start dropped in wait", start, 0);
        chk("rw held in wait", rw, 1);
        chk("write_data held in wait", write_data, 8'hA5);
        wait_fin("pass1", 3000);
        chk("pass1 pass", pass, 1);
        chk("pass1 err_count", err_count, 0);
        chk("pass1 busy", busy, 0);
        chk("pass1 starts", nstart - s0, 512);
        chk("pass1 mem[10]", mem[8'h10], 8'hB5);
        chk("pass1 mem[FF]", mem[8'hFF], 8'h5A);

        // one corrupted location, run re-pulsed mid-pass
        corrupt = 2'b01; lat = 1;
        s0 = nstart;
        pulse_run();
        repeat (20) @(negedge clk);
        chk("busy before re-run", busy, 1);
        pulse_run();
        chk("busy after re-run", busy, 1);
        chk("finished after re-run", finished, 0);
        wait_fin("pass2", 4000);
        chk("pass2 err_count", err_count, 1);
        chk("pass2 fail_addr", fail_addr, 8'h10);
        chk("pass2 fail_data", fail_data, 8'h00);
        chk("pass2 pass", pass, 0);
        chk("pass2 starts", nstart - s0, 512);

        // two corrupted locations: only the first is captured
        corrupt = 2'b11; lat = 0;
        pulse_run();
        wait_fin("pass3", 3000);
        chk("pass3 err_count", err_count, 2);
        chk("pass3 fail_addr", fail_addr, 8'h10);
        chk("pass3 pass", pass, 0);

        // reset while waiting on the read of 0x20
        corrupt = 2'b01; lat = 2;
        pulse_run();
        n = 0;
        while (!(start === 1'b1 && rw === 1'b0 && address === 8'h20) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("reached read of 0x20", start, 1);
        @(negedge clk);
        chk("err before reset", err_count, 1);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid-pass reset");
        rst = 1'b1; corrupt = 2'b00;
        s0 = nstart;
        pulse_run();
        wait_fin("pass4", 5000);
        chk("pass4 pass", pass, 1);
        chk("pass4 err_count", err_count, 0);
        chk("pass4 starts", nstart - s0, 512);

`ifdef RAM_TEST_TIMEOUT_EN
        nodone = 1'b1; lat = 0;
        pulse_run();
        wait_fin("timeout", 1200);
        chk("timeout flag", timeout, 1);
        chk("timeout pass", pass, 0);
        nodone = 1'b0;
`endif

        // DEPTH=4 master with a spurious same-cycle done
        run4 = 1'b1;
        @(negedge clk);
        run4 = 1'b0;
        n = 0;
        while (finished4 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("dut4 finished within bound", finished4, 1);
        chk("dut4 pass", pass4, 1);
        chk("dut4 err_count", err_count4, 0);
        chk("dut4 starts", log4.size(), 8);
        for (int i = 0; i < 8 && i < log4.size(); i++) begin
            chk($sformatf("dut4 txn%0d rw", i), log4[i][16], (i < 4) ? 1 : 0);
            chk($sformatf("dut4 txn%0d address", i), log4[i][15:8], i % 4);
            if (i < 4) chk($sformatf("dut4 txn%0d write_data", i), log4[i][7:0], wexp[i]);
        end

        chk("no back-to-back start", b2b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
